// File: rtl/step_dir_gen.sv
// STEP/DIR/ENN pulse generator for a TMC5130-class driver.
// Velocity mode launches at a signed period; position mode steps toward a signed target.
module step_dir_gen #(
  parameter int PW_W       = 16,
  parameter int POS_W      = 32,
  parameter int T_DIRSETUP = 2,
  parameter int T_HIGH     = 10,
  parameter int T_LOW      = 10,
  parameter int STEP_DEDGE = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             pause,
  input  logic             mode,
  input  logic [PW_W-1:0]  period,
  input  logic [POS_W-1:0] target,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_load_val,
  output logic             step,
  output logic             dir,
  output logic             enn,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             at_target
);

  localparam int T_MAX = (T_DIRSETUP > T_HIGH) ?
                         ((T_DIRSETUP > T_LOW) ? T_DIRSETUP : T_LOW) :
                         ((T_HIGH > T_LOW) ? T_HIGH : T_LOW);
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [PW_W-1:0]  P_MIN_NEG = {1'b1, {(PW_W-1){1'b0}}};
  localparam logic [PW_W-1:0]  P_SAT     = {1'b0, {(PW_W-1){1'b1}}};
  localparam logic [PW_W-1:0]  P_ZERO    = {PW_W{1'b0}};
  localparam logic [PW_W-1:0]  P_ONE     = {{(PW_W-1){1'b0}}, 1'b1};
  localparam logic [PW_W-1:0]  CNT_MAX   = {PW_W{1'b1}};
  localparam logic [POS_W-1:0] POS_ZERO  = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    PH_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]    PH_ONE    = TW'(1);
  localparam logic [TW-1:0]    DS_END    = TW'(T_DIRSETUP - 1);
  localparam logic [TW-1:0]    HI_END    = TW'(T_HIGH - 1);
  localparam logic [TW-1:0]    LO_END    = TW'(T_LOW - 1);

  typedef enum logic [1:0] {IDLE, DIRSET, HIGH, LOW} state_t;

  state_t          state;
  logic [PW_W-1:0] cnt;
  logic [PW_W-1:0] p_abs;
  logic [TW-1:0]   ph;
  logic            request;
  logic            new_dir;
  logic            launch;

  // Magnitude of the period; the most-negative code saturates instead of overflowing.
  always_comb begin
    if (!period[PW_W-1]) begin
      p_abs = period;
    end else if (period == P_MIN_NEG) begin
      p_abs = P_SAT;
    end else begin
      p_abs = ~period + P_ONE;
    end
  end

  always_comb begin
    if (mode) begin
      request = (position != target);
      new_dir = ($signed(target) < $signed(position));
    end else begin
      request = 1'b1;
      new_dir = period[PW_W-1];
    end
  end

  assign launch    = !pause && (p_abs != P_ZERO) && (cnt >= (p_abs - P_ONE)) && request;
  assign busy      = (state != IDLE);
  assign at_target = mode && (position == target) && !busy;
  assign enn       = !(resetn && enable);

  // The last LOW cycle may launch directly so back-to-back steps keep the minimum interval.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= P_ZERO;
      ph       <= PH_ZERO;
      step     <= 1'b0;
      dir      <= 1'b0;
      position <= POS_ZERO;
    end else begin
      if (!enable) begin
        state <= IDLE;
        cnt   <= P_ZERO;
        ph    <= PH_ZERO;
        if (STEP_DEDGE == 0) step <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + P_ONE;
        case (state)
          IDLE: begin
            if (launch) begin
              state <= DIRSET;
              cnt   <= P_ZERO;
              ph    <= PH_ZERO;
              dir   <= new_dir;
            end
          end
          DIRSET: begin
            if (ph == DS_END) begin
              state    <= HIGH;
              ph       <= PH_ZERO;
              step     <= (STEP_DEDGE != 0) ? ~step : 1'b1;
              position <= dir ? (position - POS_ONE) : (position + POS_ONE);
            end else begin
              ph <= ph + PH_ONE;
            end
          end
          HIGH: begin
            if (ph == HI_END) begin
              state <= LOW;
              ph    <= PH_ZERO;
              if (STEP_DEDGE == 0) step <= 1'b0;
            end else begin
              ph <= ph + PH_ONE;
            end
          end
          LOW: begin
            if (ph == LO_END) begin
              ph    <= PH_ZERO;
              state <= launch ? DIRSET : IDLE;
              if (launch) begin
                cnt <= P_ZERO;
                dir <= new_dir;
              end
            end else begin
              ph <= ph + PH_ONE;
            end
          end
          default: begin
            state <= IDLE;
            ph    <= PH_ZERO;
          end
        endcase
      end
      if (pos_load) position <= pos_load_val;
    end
  end

endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: directed scenarios plus randomized traffic, all cycles checked
// against a launch-timeline reference model.
module tb_step_dir_gen;

  localparam int TDS  = 2;
  localparam int TH   = 10;
  localparam int TL   = 10;
  localparam int BUSY = TDS + TH + TL;

  logic        clk = 1'b0;
  logic        resetn, enable, pause, mode, pos_load;
  logic [15:0] period;
  logic [31:0] target, pos_load_val;
  logic        step, dir, enn, busy, at_target;
  logic [31:0] position;

  logic        d_enable;
  logic [15:0] d_period;
  logic        d_step, d_dir, d_enn, d_busy, d_at;
  logic [31:0] d_pos;

  always #5 clk = ~clk;

  step_dir_gen dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pause(pause), .mode(mode),
    .period(period), .target(target), .pos_load(pos_load), .pos_load_val(pos_load_val),
    .step(step), .dir(dir), .enn(enn), .position(position), .busy(busy), .at_target(at_target)
  );

  step_dir_gen #(.STEP_DEDGE(1)) dut_dedge (
    .clk(clk), .resetn(resetn), .enable(d_enable), .pause(1'b0), .mode(1'b0),
    .period(d_period), .target(32'd0), .pos_load(1'b0), .pos_load_val(32'd0),
    .step(d_step), .dir(d_dir), .enn(d_enn), .position(d_pos), .busy(d_busy), .at_target(d_at)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: m_k = cycles since the launch edge (-1 when idle), m_cnt = cycles since launch/enable.
  int          m_k, m_cnt;
  logic [31:0] m_pos;
  logic        m_dir, m_step;

  logic        prev_step, rose;
  logic        dh [0:3];

  function automatic int abs_period(input logic [15:0] p);
    int v;
    v = int'($signed(p));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic model_reset();
    m_k = -1; m_cnt = 0; m_pos = 32'd0; m_dir = 1'b0; m_step = 1'b0;
  endtask

  task automatic model_step();
    int   p;
    logic req, nd, can;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (!enable) begin
      m_k = -1; m_cnt = 0; m_step = 1'b0;
    end else begin
      p   = abs_period(period);
      req = mode ? (m_pos != target) : 1'b1;
      nd  = mode ? ($signed(target) < $signed(m_pos)) : period[15];
      can = ((m_k < 0) || (m_k >= BUSY - 1)) && !pause && (p != 0) && (m_cnt >= p - 1) && req;
      if (can) begin
        m_k = 0; m_cnt = 0; m_dir = nd;
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (m_k >= 0) begin
          m_k++;
          if (m_k >= BUSY) m_k = -1;
        end
      end
      if (m_k == TDS) begin
        m_pos  = m_dir ? (m_pos - 32'd1) : (m_pos + 32'd1);
        m_step = 1'b1;
      end
      if (m_k == TDS + TH) m_step = 1'b0;
    end
    if (pos_load) m_pos = pos_load_val;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_busy;
    exp_busy = (m_k >= 0);
    chk("step", 32'(step), 32'(m_step));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("position", position, m_pos);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("at_target", 32'(at_target), 32'(mode && (m_pos == target) && !exp_busy));
    chk("enn", 32'(enn), 32'(!(resetn && enable)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    rose = step && !prev_step;
    prev_step = step;
    dh[3] = dh[2]; dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = dir;
  endtask

  task automatic wait_rise(input int budget, output int n);
    n = 0;
    rose = 1'b0;
    while (!rose && n < budget) begin
      tick();
      n++;
    end
    chk("rise_within_budget", 32'(rose), 32'd1);
  endtask

  initial begin
    int n, h, r, t_last, toggles;
    logic [31:0] pos_before;
    logic        pd;

    resetn = 1'b0; enable = 1'b0; pause = 1'b0; mode = 1'b0; pos_load = 1'b0;
    period = 16'd0; target = 32'd0; pos_load_val = 32'd0;
    d_enable = 1'b0; d_period = 16'd0;
    prev_step = 1'b0; rose = 1'b0;
    for (int i = 0; i < 4; i++) dh[i] = 1'b0;
    model_reset();

    repeat (3) tick();
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_position", position, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_enn", 32'(enn), 32'd1);
    resetn = 1'b1;
    repeat (2) tick();

    // Velocity +100: first rise 101 edges after the first enabled edge, then every 100.
    period = 16'd100; enable = 1'b1;
    wait_rise(300, n);
    chk("first_rise_latency", 32'(n), 32'd102);
    for (int i = 0; i < 9; i++) begin
      wait_rise(300, n);
      chk("interval_p100", 32'(n), 32'd100);
    end
    chk("pos_after_10", position, 32'd10);
    h = 1;
    while (step && h < 50) begin
      tick();
      if (step) h++;
    end
    chk("high_width", 32'(h), 32'd10);

    // Short period: the step interval is bounded by the pulse timing.
    period = 16'd5;
    wait_rise(100, n);
    wait_rise(100, n);
    chk("interval_p5", 32'(n), 32'(BUSY));
    wait_rise(100, n);
    chk("interval_p5_b", 32'(n), 32'(BUSY));

    // Reverse mid-pulse: new dir appears exactly TDS edges before the next rise.
    period = 16'd50;
    wait_rise(200, n);
    tick();
    pos_before = position;
    period = 16'hFFCE;
    wait_rise(200, n);
    chk("dir_at_rise", 32'(dir), 32'd1);
    chk("dir_setup_2", 32'(dh[2]), 32'd1);
    chk("dir_old_3", 32'(dh[3]), 32'd0);
    chk("pos_decrement", position, pos_before - 32'd1);

    // Position mode 0 -> 7 -> -3.
    enable = 1'b0; mode = 1'b1; pos_load = 1'b1; pos_load_val = 32'd0;
    target = 32'd7; period = 16'd30;
    tick();
    pos_load = 1'b0; enable = 1'b1;
    r = 0; n = 0;
    tick();
    while (!at_target && n < 2000) begin
      if (rose) r++;
      tick();
      n++;
    end
    chk("reach_7", 32'(at_target), 32'd1);
    chk("pulses_to_7", 32'(r), 32'd7);
    chk("pos_7", position, 32'd7);
    r = 0;
    repeat (80) begin
      tick();
      if (rose) r++;
    end
    chk("idle_at_7", 32'(r), 32'd0);
    target = 32'hFFFF_FFFD;
    r = 0; n = 0;
    tick();
    while (!at_target && n < 3000) begin
      if (rose) begin
        r++;
        chk("dir_neg", 32'(dir), 32'd1);
      end
      tick();
      n++;
    end
    chk("reach_m3", 32'(at_target), 32'd1);
    chk("pulses_to_m3", 32'(r), 32'd10);
    chk("pos_m3", position, 32'hFFFF_FFFD);

    // Pause in HIGH: current pulse completes, nothing new starts.
    mode = 1'b0; period = 16'd30;
    wait_rise(200, n);
    pause = 1'b1;
    h = 1;
    while (step && h < 50) begin
      tick();
      if (step) h++;
    end
    chk("pause_high", 32'(h), 32'd10);
    h = busy ? 1 : 0;
    while (busy && h < 50) begin
      tick();
      if (busy) h++;
    end
    chk("pause_low", 32'(h), 32'(TL));
    r = 0;
    repeat (100) begin
      tick();
      if (rose) r++;
    end
    chk("pause_no_edges", 32'(r), 32'd0);

    // Async reset during HIGH.
    pause = 1'b0;
    wait_rise(200, n);
    repeat (3) tick();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_step_now", 32'(step), 32'd0);
    chk("rst_pos_now", position, 32'd0);
    chk("rst_busy_now", 32'(busy), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;

    // Wrap from max positive.
    enable = 1'b0; period = 16'd30; pos_load = 1'b1; pos_load_val = 32'h7FFF_FFFF;
    tick();
    pos_load = 1'b0; enable = 1'b1;
    wait_rise(200, n);
    chk("pos_wrap", position, 32'h8000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      pos_load = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 6))
          0: period = 16'd0;
          1: period = 16'h8000;
          default: period = 16'(int'($urandom_range(0, 120)) - 60);
        endcase
      end
      if ($urandom_range(0, 49) == 0) target = 32'(int'($urandom_range(0, 30)) - 15);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        pos_load = 1'b1;
        pos_load_val = 32'(int'($urandom_range(0, 40)) - 20);
      end
      tick();
    end
    pos_load = 1'b0;

    // Double-edge instance: one toggle per step, spaced by the period.
    d_period = 16'd40; d_enable = 1'b1;
    pd = d_step; toggles = 0; t_last = 0; n = 0;
    while (toggles < 4 && n < 400) begin
      tick();
      n++;
      if (d_step != pd) begin
        toggles++;
        chk("dedge_pos", d_pos, 32'(toggles));
        if (toggles > 1) chk("dedge_interval", 32'(n - t_last), 32'd40);
        t_last = n;
      end
      pd = d_step;
    end
    chk("dedge_toggles", 32'(toggles), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
